// File: rtl/uart_pkg.sv
// Shared UART types: scaler width and the divider type used by the register
// block and the baud prescaler.
package uart_pkg;
    localparam int ScalerWidth = 16;
    typedef logic [ScalerWidth-1:0] scaler_t;
endpackage

// File: rtl/uart_baud_prescaler.sv
// Programmable clock-enable generator: one-cycle strobe every N clocks plus a
// one-cycle half-period pulse for mid-bit sampling.
module uart_baud_prescaler
    import uart_pkg::*;
#(
    parameter int unsigned InitialDivider = 8
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_en,
    input  scaler_t i_scaler,
    output logic    o_strobe,
    output logic    o_half
);

    scaler_t div_q, div_d;
    scaler_t cnt_q, cnt_d;
    logic    strobe_q, strobe_d;
    logic    half_q, half_d;

    scaler_t eff;
    scaler_t half_pt;
    logic    period_end;

    // A zero scaler would never terminate a period, so it is clamped to 1.
    assign eff        = (i_scaler == '0) ? scaler_t'(1) : i_scaler;
    assign half_pt    = ((div_q >> 1) == '0) ? scaler_t'(1) : (div_q >> 1);
    assign period_end = (cnt_q == div_q - scaler_t'(1));

    always_comb begin
        div_d    = div_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        half_d   = 1'b0;
        if (!i_en) begin
            cnt_d = '0;
            div_d = eff;
        end else begin
            strobe_d = period_end;
            half_d   = (cnt_q == half_pt - scaler_t'(1));
            if (period_end) begin
                // New divider is only adopted at a period boundary.
                cnt_d = '0;
                div_d = eff;
            end else begin
                cnt_d = cnt_q + scaler_t'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_q    <= scaler_t'(InitialDivider);
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            half_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            half_q   <= half_d;
        end
    end

    assign o_strobe = strobe_q;
    assign o_half   = half_q;

endmodule

// File: tb/tb_uart_baud_prescaler.sv
// Directed bench for uart_baud_prescaler: expected pulses are queued per edge
// and compared one cycle-step later against the outputs.
module tb_uart_baud_prescaler;
    import uart_pkg::*;

    logic    clk;
    logic    rst;
    logic    en;
    scaler_t scaler;
    logic    strobe;
    logic    half;

    int checks   = 0;
    int failures = 0;
    int n_strobe = 0;
    int n_half   = 0;

    typedef struct {
        logic  s;
        logic  h;
        string tag;
    } exp_t;

    exp_t sb[$];

    uart_baud_prescaler #(.InitialDivider(8)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_scaler(scaler),
        .o_strobe(strobe),
        .o_half  (half)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pulses on enabled edge k (1-based) of a steady period of n.
    function automatic logic exp_s(input int k, input int n);
        return (k % n) == 0;
    endfunction

    function automatic logic exp_h(input int k, input int n);
        int h;
        h = (n / 2 < 1) ? 1 : n / 2;
        return (k % n) == (h % n);
    endfunction

    task automatic compare_head();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (strobe === e.s && half === e.h)
        else begin
            failures++;
            $error("FAIL %s: got strobe=%0b half=%0b, expected strobe=%0b half=%0b",
                   e.tag, strobe, half, e.s, e.h);
        end
        if (strobe === 1'b1) n_strobe++;
        if (half === 1'b1) n_half++;
    endtask

    task automatic tick(input logic s, input logic h, input string tag);
        sb.push_back('{s, h, tag});
        @(posedge clk);
        #1;
        compare_head();
    endtask

    task automatic check_now(input logic s, input logic h, input string tag);
        sb.push_back('{s, h, tag});
        compare_head();
    endtask

    task automatic run_pattern(input int k0, input int k1, input int n, input string tag);
        for (int k = k0; k <= k1; k++) begin
            tick(exp_s(k, n), exp_h(k, n), $sformatf("%s_e%0d", tag, k));
        end
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        scaler = 16'd8;

        // Reset held for two cycles, then idle with enable low.
        tick(1'b0, 1'b0, "rst_hold1");
        tick(1'b0, 1'b0, "rst_hold2");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, "idle_en_low");

        // Steady state, N = 8, 100 enabled edges.
        en       = 1'b1;
        n_strobe = 0;
        n_half   = 0;
        run_pattern(1, 100, 8, "n8");
        checks++;
        assert (n_strobe == 12)
        else begin
            failures++;
            $error("FAIL n8_strobe_count: got %0d, expected 12", n_strobe);
        end
        checks++;
        assert (n_half == 13)
        else begin
            failures++;
            $error("FAIL n8_half_count: got %0d, expected 13", n_half);
        end
        en = 1'b0;
        tick(1'b0, 1'b0, "n8_disable");

        // Scaler 8 -> 5 sampled at e3: current period stays 8.
        en = 1'b1;
        run_pattern(1, 2, 8, "chg_old");
        scaler = 16'd5;
        run_pattern(3, 8, 8, "chg_old");
        run_pattern(1, 15, 5, "chg_new");
        en = 1'b0;

        // Scaler 0 behaves as 1.
        scaler = 16'd0;
        tick(1'b0, 1'b0, "n0_idle");
        en = 1'b1;
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, "n0_every");
        en = 1'b0;

        // Scaler 1, with an asynchronous reset landing while both outputs are high.
        scaler = 16'd1;
        tick(1'b0, 1'b0, "n1_idle");
        en = 1'b1;
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, "n1_every");
        #2;
        rst = 1'b1;
        #1;
        check_now(1'b0, 1'b0, "n1_async_rst");
        tick(1'b0, 1'b0, "n1_rst_hold");
        en  = 1'b0;
        rst = 1'b0;

        // Scaler 3: half after e1, strobe after e3.
        scaler = 16'd3;
        tick(1'b0, 1'b0, "n3_idle");
        en = 1'b1;
        run_pattern(1, 9, 3, "n3");
        en = 1'b0;

        // Enable toggle: enable low for edges 6..8, restart from zero.
        scaler = 16'd8;
        tick(1'b0, 1'b0, "tog_idle");
        en = 1'b1;
        run_pattern(1, 5, 8, "tog_pre");
        en = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, "tog_off");
        en = 1'b1;
        run_pattern(1, 16, 8, "tog_post");
        en = 1'b0;

        // Async reset at cnt = 5; scaler changed to 4 during reset.
        tick(1'b0, 1'b0, "ar_idle");
        en = 1'b1;
        run_pattern(1, 5, 8, "ar_pre");
        #2;
        rst = 1'b1;
        #1;
        check_now(1'b0, 1'b0, "ar_immediate");
        scaler = 16'd4;
        tick(1'b0, 1'b0, "ar_hold1");
        tick(1'b0, 1'b0, "ar_hold2");
        rst = 1'b0;
        run_pattern(1, 8, 8, "ar_first");
        run_pattern(1, 8, 4, "ar_later");
        en = 1'b0;
        tick(1'b0, 1'b0, "ar_disable");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
